// File: rtl/read_src_fsm.sv
// Read-side DMA engine: issues one AXI4 INCR read burst per descriptor and streams the
// R beats straight into the DMA data FIFO, reporting done or error at the end of the burst.
module read_src_fsm #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_desc_go,
  input  logic [ADDR_W-1:0] i_desc_src_addr,
  input  logic [LEN_W-1:0]  i_desc_length,
  input  logic              i_csr_reset_dispatcher,
  output logic              o_arvalid,
  input  logic              i_arready,
  output logic [ADDR_W-1:0] o_araddr,
  output logic [7:0]        o_arlen,
  output logic [2:0]        o_arsize,
  output logic [1:0]        o_arburst,
  input  logic              i_rvalid,
  output logic              o_rready,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rlast,
  input  logic              i_fifo_full,
  output logic              o_fifo_wr_en,
  output logic [DATA_W-1:0] o_fifo_wr_data,
  output logic              o_rd_fsm_done,
  output logic              o_rd_busy,
  output logic              o_rd_error
);

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_ADDR = 4'b0010;
  localparam logic [3:0] S_RD   = 4'b0100;
  localparam logic [3:0] S_ERR  = 4'b1000;

  localparam logic [2:0]       AR_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(256);

  logic [3:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_arlen;
  logic [7:0]        r_cnt;
  logic              r_resp_err;
  logic              r_arvalid;
  logic              r_done;

  logic w_len_ok;
  logic w_rready;
  logic w_r_hs;
  logic w_final_beat;
  logic w_err_now;

  assign w_len_ok     = (i_desc_length != '0) && (i_desc_length <= MAX_LEN);
  assign w_rready     = (r_state == S_RD) && !i_fifo_full;
  assign w_r_hs       = i_rvalid && w_rready;
  assign w_final_beat = (r_cnt == r_arlen);
  // Include the current beat's response so an error on the last beat is not missed.
  assign w_err_now    = r_resp_err || (i_rresp != 2'b00);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_arlen    <= '0;
      r_cnt      <= '0;
      r_resp_err <= 1'b0;
      r_arvalid  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_desc_go) begin
            r_addr     <= i_desc_src_addr;
            r_arlen    <= 8'(i_desc_length - LEN_W'(1));
            r_cnt      <= '0;
            r_resp_err <= 1'b0;
            if (w_len_ok) begin
              r_state   <= S_ADDR;
              r_arvalid <= 1'b1;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_ADDR: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= S_RD;
          end
        end
        S_RD: begin
          if (w_r_hs) begin
            r_cnt <= r_cnt + 8'd1;
            if (i_rresp != 2'b00) r_resp_err <= 1'b1;
            if (w_final_beat && i_rlast) begin
              if (w_err_now) begin
                r_state <= S_ERR;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end else if (w_final_beat || i_rlast) begin
              r_state <= S_ERR;
            end
          end
        end
        S_ERR: begin
          if (i_csr_reset_dispatcher) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_arvalid      = r_arvalid;
  assign o_araddr       = r_addr;
  assign o_arlen        = r_arlen;
  assign o_arsize       = AR_SIZE;
  assign o_arburst      = 2'b01;
  assign o_rready       = w_rready;
  assign o_fifo_wr_en   = w_r_hs;
  assign o_fifo_wr_data = i_rdata;
  assign o_rd_fsm_done  = r_done;
  assign o_rd_busy      = (r_state != S_IDLE);
  assign o_rd_error     = (r_state == S_ERR);

endmodule

// File: tb/tb_read_src_fsm.sv
// Self-checking bench for read_src_fsm: FIFO writes are checked against a scoreboard queue
// filled as R beats are driven.
module tb_read_src_fsm;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int LW = 9;

  logic          clk, reset, desc_go, csr_reset_dispatcher;
  logic [AW-1:0] desc_src_addr;
  logic [LW-1:0] desc_length;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid, rready, rlast;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          fifo_full, fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          rd_fsm_done, rd_busy, rd_error;

  read_src_fsm #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .i_clk(clk), .i_reset(reset), .i_desc_go(desc_go), .i_desc_src_addr(desc_src_addr),
    .i_desc_length(desc_length), .i_csr_reset_dispatcher(csr_reset_dispatcher),
    .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arlen(arlen),
    .o_arsize(arsize), .o_arburst(arburst), .i_rvalid(rvalid), .o_rready(rready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_fifo_full(fifo_full),
    .o_fifo_wr_en(fifo_wr_en), .o_fifo_wr_data(fifo_wr_data), .o_rd_fsm_done(rd_fsm_done),
    .o_rd_busy(rd_busy), .o_rd_error(rd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_chk, n_err, n_wr, n_done;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_w;
  bit            tog_en;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every FIFO push must match the oldest beat driven and not yet seen.
  always @(negedge clk) begin
    if (rd_fsm_done) n_done++;
    if (fifo_wr_en) begin
      n_wr++;
      chk("wr_needs_hs", 64'(rvalid & rready), 64'd1);
      if (sb_q.size() == 0) begin
        chk("wr_unexpected", 64'(fifo_wr_en), 64'd0);
      end else begin
        exp_w = sb_q.pop_front();
        chk("wr_data", fifo_wr_data[63:0], exp_w[63:0]);
        chk("wr_word", 64'(fifo_wr_data == exp_w), 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] l);
    desc_go       = 1'b1;
    desc_src_addr = a;
    desc_length   = l;
    tick();
    desc_go = 1'b0;
  endtask

  task automatic ar_accept(input int stall, input logic [AW-1:0] a, input logic [7:0] alen);
    for (int i = 0; i < stall; i++) begin
      chk("ar_stall_valid", 64'(arvalid), 64'd1);
      chk("ar_stall_addr", araddr, a);
      chk("ar_stall_len", 64'(arlen), 64'(alen));
      tick();
    end
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("araddr", araddr, a);
    chk("arlen", 64'(arlen), 64'(alen));
    chk("arsize", 64'(arsize), 64'd6);
    chk("arburst", 64'(arburst), 64'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("arvalid_drop", 64'(arvalid), 64'd0);
  endtask

  task automatic beat(input logic [63:0] v, input logic [1:0] resp, input logic last,
                      input logic mirror);
    logic got;
    bit   ok;
    rvalid = 1'b1;
    rdata  = {8{v}};
    rresp  = resp;
    rlast  = last;
    sb_q.push_back({8{v}});
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      got = rready;
      if (mirror) chk("rready_mirror", 64'(rready), 64'(!fifo_full));
      tick();
      if (got) begin
        ok = 1'b1;
        break;
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    if (!ok) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_err();
    csr_reset_dispatcher = 1'b1;
    tick();
    csr_reset_dispatcher = 1'b0;
    chk("err_cleared", 64'(rd_error), 64'd0);
    chk("idle_after_clear", 64'(rd_busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, d0;
    logic [LW-1:0] bad_len[2];
    reset = 1'b1; desc_go = 1'b0; desc_src_addr = '0; desc_length = '0;
    csr_reset_dispatcher = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    rresp = 2'b00; rlast = 1'b0; fifo_full = 1'b0; tog_en = 1'b0;
    bad_len[0] = 9'd0;
    bad_len[1] = 9'd300;
    tick(); tick();
    reset = 1'b0;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_done", 64'(rd_fsm_done), 64'd0);
    chk("rst_error", 64'(rd_error), 64'd0);
    chk("rst_busy", 64'(rd_busy), 64'd0);

    // len=4 clean burst
    w0 = n_wr; d0 = n_done;
    issue(64'h1000, 9'd4);
    chk("issue_latency", 64'(arvalid), 64'd1);
    ar_accept(0, 64'h1000, 8'd3);
    for (int i = 0; i < 4; i++) beat(64'(i), 2'b00, i == 3, 1'b0);
    chk("t1_done", 64'(rd_fsm_done), 64'd1);
    chk("t1_idle", 64'(rd_busy), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(rd_fsm_done), 64'd0);
    chk("t1_writes", 64'(n_wr - w0), 64'd4);
    chk("t1_done_cnt", 64'(n_done - d0), 64'd1);

    // len=8 with AR stall and FIFO backpressure toggling
    w0 = n_wr; d0 = n_done;
    issue(64'h2000, 9'd8);
    ar_accept(5, 64'h2000, 8'd7);
    tog_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) beat(64'hA0 + 64'(i), 2'b00, i == 7, 1'b1);
        tog_en = 1'b0;
      end
      begin
        for (int i = 0; i < 100 && tog_en; i++) begin
          tick();
          if (tog_en) fifo_full = ~fifo_full;
        end
      end
    join
    fifo_full = 1'b0;
    tick();
    chk("t2_writes", 64'(n_wr - w0), 64'd8);
    chk("t2_done_cnt", 64'(n_done - d0), 64'd1);
    chk("t2_idle", 64'(rd_busy), 64'd0);

    // len=2, SLVERR on last beat
    w0 = n_wr; d0 = n_done;
    issue(64'h3000, 9'd2);
    ar_accept(0, 64'h3000, 8'd1);
    beat(64'hB0, 2'b00, 1'b0, 1'b0);
    beat(64'hB1, 2'b10, 1'b1, 1'b0);
    chk("t3_error", 64'(rd_error), 64'd1);
    chk("t3_busy", 64'(rd_busy), 64'd1);
    tick();
    chk("t3_writes", 64'(n_wr - w0), 64'd2);
    chk("t3_no_done", 64'(n_done - d0), 64'd0);
    clear_err();

    // len=4, early rlast on beat 2
    w0 = n_wr; d0 = n_done;
    issue(64'h4000, 9'd4);
    ar_accept(0, 64'h4000, 8'd3);
    for (int i = 0; i < 3; i++) beat(64'hC0 + 64'(i), 2'b00, i == 2, 1'b0);
    chk("t4_error", 64'(rd_error), 64'd1);
    tick();
    chk("t4_writes", 64'(n_wr - w0), 64'd3);
    chk("t4_no_done", 64'(n_done - d0), 64'd0);
    clear_err();

    // illegal lengths: no AR at all
    for (int k = 0; k < 2; k++) begin
      issue(64'h5000, bad_len[k]);
      chk("badlen_error", 64'(rd_error), 64'd1);
      arready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        chk("badlen_no_ar", 64'(arvalid), 64'd0);
        tick();
      end
      arready = 1'b0;
      clear_err();
    end

    // reset mid-burst, then a fresh len=1 descriptor
    w0 = n_wr; d0 = n_done;
    issue(64'h6000, 9'd4);
    ar_accept(0, 64'h6000, 8'd3);
    beat(64'hD0, 2'b00, 1'b0, 1'b0);
    beat(64'hD1, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_idle", 64'(rd_busy), 64'd0);
    rvalid = 1'b1;
    rdata  = {8{64'hDEAD}};
    for (int i = 0; i < 3; i++) begin
      chk("mid_rst_rready", 64'(rready), 64'd0);
      tick();
    end
    rvalid = 1'b0;
    chk("mid_rst_writes", 64'(n_wr - w0), 64'd2);
    issue(64'h7000, 9'd1);
    ar_accept(0, 64'h7000, 8'd0);
    beat(64'hE0, 2'b00, 1'b1, 1'b0);
    chk("t6_done", 64'(rd_fsm_done), 64'd1);
    tick();
    chk("t6_done_cnt", 64'(n_done - d0), 64'd1);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
